energy_accumulator: RTL and testbench
=====================================

Name: energy_accumulator

Overview:
Downstream of partial_energy_calc. Consumes one signed local energy per spin, sequentially over all DATASPIN spins, and produces the total Ising energy of the current spin configuration. A valid/ready handshake is used on both the input and output sides. The block exposes the index of the spin it expects next, so the upstream sequencer can select the matching weight row and current spin.

Parameters:
DATASPIN, 256, number of spins (local energies) per frame; must be >= 2
LOCAL_ENERGY_BIT, 16, width of signed local energy input
TOTAL_ENERGY_BIT, 32, width of signed total energy output; elaboration check TOTAL_ENERGY_BIT >= LOCAL_ENERGY_BIT + $clog2(DATASPIN), so overflow cannot occur
IDX_BIT, $clog2(DATASPIN), derived, width of spin index

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous abort of the current frame
energy_valid_i  input  1  local energy valid
energy_ready_o  output  1  block accepts a local energy
energy_i  input  LOCAL_ENERGY_BIT  signed local energy from partial_energy_calc
spin_idx_o  output  IDX_BIT  index of the spin whose local energy is expected next
total_valid_o  output  1  total energy valid
total_ready_i  input  1  consumer accepts the total
total_energy_o  output  TOTAL_ENERGY_BIT  signed total energy
busy_o  output  1  high when at least one local energy of the current frame has been accepted, or the total is pending

Behaviour:
- Reset (async, rst_i=1):
  - state=ACCUM; acc=0; cnt=0; total register=0.
  - Outputs: energy_ready_o=1 after reset release (0 while rst_i is high), total_valid_o=0, total_energy_o=0, spin_idx_o=0, busy_o=0.
- Input handshake fires when energy_valid_i && energy_ready_o.
- FSM states: ACCUM, OUTPUT.
- ACCUM:
  - energy_ready_o=1, total_valid_o=0.
  - On handshake with cnt<DATASPIN-1: acc <= acc + sign_extend(energy_i); cnt <= cnt+1.
  - On handshake with cnt==DATASPIN-1: total register <= acc + sign_extend(energy_i); acc <= 0; cnt <= 0; state <= OUTPUT.
  - Without a handshake: hold all state. energy_valid_i gaps of any length are legal.
- OUTPUT:
  - energy_ready_o=0, total_valid_o=1, total_energy_o stable.
  - On total_valid_o && total_ready_i: state <= ACCUM. The input side accepts again on the following cycle; there is no same-cycle bypass.
  - If total_ready_i is held low: hold indefinitely; energy_valid_i is ignored.
- Latency: total_valid_o rises on the first clock edge after the last input handshake (1 cycle).
- Throughput: one local energy per cycle; each frame costs DATASPIN + 1 cycles minimum.
- spin_idx_o = cnt, registered. It is 0 in OUTPUT.
- Arithmetic: two's complement, with energy_i sign-extended to TOTAL_ENERGY_BIT. No saturation is needed because of the parameter check.
- flush_i=1, in any state:
  - Next edge: acc=0, cnt=0, state=ACCUM, total_valid_o=0. total_energy_o keeps its last value.
  - flush_i has priority over a simultaneous input or output handshake; that transfer is discarded, i.e. not counted.
- Reset mid-frame: partial sums are lost. After release the block starts a new frame at index 0.
- No X propagation: energy_i is sampled only on a handshake.

Decomposition:
- Shared package lagd_energy_pkg:
  - LOCAL_ENERGY_BIT and TOTAL_ENERGY_BIT defaults.
  - typedefs local_energy_t and total_energy_t (signed).
  - FSM state enum acc_state_e {ACCUM, OUTPUT}.
- No sub-module: a single module holding the FSM, index counter and accumulator, about 150 lines of RTL.

Test Plan:
- All 256 inputs 0, valid every cycle, total_ready_i=1 → total_valid_o rises 1 cycle after the 256th handshake; total_energy_o=0; spin_idx_o counts 0..255.
- All 256 inputs = 112 → total_energy_o=28672.
- All 256 inputs = 1792 → total_energy_o=458752. This exceeds 16 bits and checks the widening.
- Input i = i−128 for i=0..255, with random valid gaps → total_energy_o=−128. Also check that spin_idx_o holds during gaps.
- Backpressure: total_ready_i low for 5 cycles after the total → total_valid_o=1, total_energy_o stable, energy_ready_o=0, and inputs offered during the stall are not counted. The next frame of all 7 → 1792.
- flush_i pulsed after 100 inputs of 1000, with a handshake in the same cycle, then a full frame of 1s → total_energy_o=256. Separately, rst_i asserted mid-frame → outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/lagd_energy_pkg.sv
// Shared definitions for the energy datapath: default widths, signed
// energy types and the accumulator FSM state encoding.
package lagd_energy_pkg;

    localparam int DATASPIN_DEFAULT         = 256;
    localparam int LOCAL_ENERGY_BIT_DEFAULT = 16;
    localparam int TOTAL_ENERGY_BIT_DEFAULT = 32;

    typedef logic signed [LOCAL_ENERGY_BIT_DEFAULT-1:0] local_energy_t;
    typedef logic signed [TOTAL_ENERGY_BIT_DEFAULT-1:0] total_energy_t;

    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } acc_state_e;

endpackage : lagd_energy_pkg

// File: rtl/energy_accumulator.sv
// Sums one signed local energy per spin over a full frame of DATASPIN spins
// and presents the total Ising energy on a valid/ready output. The index of
// the next expected spin is exposed so the upstream sequencer can fetch the
// matching weight row. flush_i acts as the synchronous abort of a frame.
module energy_accumulator
    import lagd_energy_pkg::*;
#(
    parameter  int DATASPIN         = DATASPIN_DEFAULT,
    parameter  int LOCAL_ENERGY_BIT = LOCAL_ENERGY_BIT_DEFAULT,
    parameter  int TOTAL_ENERGY_BIT = TOTAL_ENERGY_BIT_DEFAULT,
    localparam int IDX_BIT          = $clog2(DATASPIN)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               energy_valid_i,
    output logic                               energy_ready_o,
    input  logic signed [LOCAL_ENERGY_BIT-1:0] energy_i,
    output logic        [IDX_BIT-1:0]          spin_idx_o,
    output logic                               total_valid_o,
    input  logic                               total_ready_i,
    output logic signed [TOTAL_ENERGY_BIT-1:0] total_energy_o,
    output logic                               busy_o
);

    // The total is wide enough that a full frame of extreme local energies
    // can never wrap, so the accumulator needs no saturation logic.
    if (DATASPIN < 2) begin : g_spin_check
        $fatal(1, "energy_accumulator: DATASPIN must be >= 2");
    end
    if (TOTAL_ENERGY_BIT < LOCAL_ENERGY_BIT + $clog2(DATASPIN)) begin : g_width_check
        $fatal(1, "energy_accumulator: TOTAL_ENERGY_BIT too narrow for DATASPIN sums");
    end

    localparam logic [IDX_BIT-1:0] IDX_ZERO = {IDX_BIT{1'b0}};
    localparam logic [IDX_BIT-1:0] IDX_ONE  = {{(IDX_BIT-1){1'b0}}, 1'b1};
    localparam logic [IDX_BIT-1:0] IDX_LAST = IDX_BIT'(DATASPIN - 1);
    localparam logic signed [TOTAL_ENERGY_BIT-1:0] ACC_ZERO = {TOTAL_ENERGY_BIT{1'b0}};

    // Two's complement widening of a local energy to the accumulator width.
    function automatic logic signed [TOTAL_ENERGY_BIT-1:0] sext_energy(
        input logic signed [LOCAL_ENERGY_BIT-1:0] e
    );
        return {{(TOTAL_ENERGY_BIT-LOCAL_ENERGY_BIT){e[LOCAL_ENERGY_BIT-1]}}, e};
    endfunction

    acc_state_e                         state_r,  state_s;
    logic signed [TOTAL_ENERGY_BIT-1:0] acc_r,    acc_s;
    logic signed [TOTAL_ENERGY_BIT-1:0] total_r,  total_s;
    logic        [IDX_BIT-1:0]          cnt_r,    cnt_s;
    logic                               busy_r,   busy_s;
    logic                               in_hs_s;

    // Input handshake only while collecting; energy_i is never looked at otherwise.
    always_comb begin
        in_hs_s = energy_valid_i && (state_r == ACCUM);
    end

    // Next-state computation for the FSM, counter, accumulator and total.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        total_s = total_r;
        cnt_s   = cnt_r;
        if (flush_i) begin
            // Abort wins over any simultaneous transfer; total keeps its value.
            state_s = ACCUM;
            acc_s   = ACC_ZERO;
            cnt_s   = IDX_ZERO;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (in_hs_s && (cnt_r == IDX_LAST)) begin
                        total_s = acc_r + sext_energy(energy_i);
                        acc_s   = ACC_ZERO;
                        cnt_s   = IDX_ZERO;
                        state_s = OUTPUT;
                    end else if (in_hs_s) begin
                        acc_s = acc_r + sext_energy(energy_i);
                        cnt_s = cnt_r + IDX_ONE;
                    end else begin
                        acc_s = acc_r;
                    end
                end
                OUTPUT: begin
                    if (total_ready_i) begin
                        state_s = ACCUM;
                    end else begin
                        state_s = OUTPUT;
                    end
                end
                default: begin
                    state_s = ACCUM;
                    acc_s   = ACC_ZERO;
                    cnt_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // Busy once the frame has a partial sum or a total is waiting to drain.
    always_comb begin
        if ((cnt_s != IDX_ZERO) || (state_s == OUTPUT)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ACCUM;
            acc_r   <= ACC_ZERO;
            total_r <= ACC_ZERO;
            cnt_r   <= IDX_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            total_r <= total_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
        end
    end

    // Outputs are decodes of registered state; ready is held low while in reset.
    always_comb begin
        energy_ready_o = (state_r == ACCUM) && !rst_i;
        total_valid_o  = (state_r == OUTPUT);
        total_energy_o = total_r;
        spin_idx_o     = cnt_r;
        busy_o         = busy_r;
    end

endmodule : energy_accumulator

// File: tb/tb_energy_accumulator.sv
// Directed self-checking bench for energy_accumulator (DATASPIN = 256).
module tb_energy_accumulator;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               energy_valid;
    logic               energy_ready;
    logic signed [15:0] energy;
    logic        [7:0]  spin_idx;
    logic               total_valid;
    logic               total_ready;
    logic signed [31:0] total_energy;
    logic               busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    energy_accumulator #(
        .DATASPIN         (256),
        .LOCAL_ENERGY_BIT (16),
        .TOTAL_ENERGY_BIT (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .energy_valid_i (energy_valid),
        .energy_ready_o (energy_ready),
        .energy_i       (energy),
        .spin_idx_o     (spin_idx),
        .total_valid_o  (total_valid),
        .total_ready_i  (total_ready),
        .total_energy_o (total_energy),
        .busy_o         (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted local energy; checks the index the block expects.
    task automatic send(input logic signed [15:0] v, input int idx);
        energy_valid = 1'b1;
        energy       = v;
        if (idx % 64 == 0 || idx == 255) begin
            chk("spin_idx", longint'(spin_idx), longint'(idx));
            chk("ready_accum", longint'(energy_ready), 64'sd1);
            chk("valid_low_accum", longint'(total_valid), 64'sd0);
        end
        tick();
        energy_valid = 1'b0;
        energy       = 16'sd0;
    endtask

    task automatic frame_const(input logic signed [15:0] v);
        for (int i = 0; i < 256; i++) send(v, i);
    endtask

    // Total must be presented one edge after the last handshake.
    task automatic check_total(input string tag, input longint exp);
        chk({tag, "_valid"}, longint'(total_valid), 64'sd1);
        chk({tag, "_energy"}, longint'(total_energy), exp);
        chk({tag, "_ready_low"}, longint'(energy_ready), 64'sd0);
        chk({tag, "_idx0"}, longint'(spin_idx), 64'sd0);
        chk({tag, "_busy"}, longint'(busy), 64'sd1);
    endtask

    task automatic ack();
        total_ready = 1'b1;
        tick();
        total_ready = 1'b0;
        chk("ack_valid_low", longint'(total_valid), 64'sd0);
        chk("ack_ready_high", longint'(energy_ready), 64'sd1);
        chk("ack_busy_low", longint'(busy), 64'sd0);
    endtask

    initial begin
        logic signed [31:0] held;
        rst          = 1'b1;
        flush        = 1'b0;
        energy_valid = 1'b0;
        energy       = 16'sd0;
        total_ready  = 1'b0;
        #12;
        chk("rst_ready", longint'(energy_ready), 64'sd0);
        chk("rst_valid", longint'(total_valid), 64'sd0);
        chk("rst_energy", longint'(total_energy), 64'sd0);
        chk("rst_idx", longint'(spin_idx), 64'sd0);
        chk("rst_busy", longint'(busy), 64'sd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", longint'(energy_ready), 64'sd1);
        @(posedge clk);
        #1;

        // All zeros, valid every cycle.
        frame_const(16'sd0);
        check_total("zeros", 64'sd0);
        ack();

        // All 112 -> 28672.
        frame_const(16'sd112);
        check_total("c112", 64'sd28672);
        ack();

        // All 1792 -> 458752 (wider than 16 bits).
        frame_const(16'sd1792);
        check_total("c1792", 64'sd458752);
        ack();

        // Ramp i-128 with random idle gaps; index must hold across gaps.
        for (int i = 0; i < 256; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                energy = 16'($urandom);
                tick();
                if (g == 0 && (i % 32) == 5) begin
                    chk("gap_idx_hold", longint'(spin_idx), longint'(i));
                end
            end
            send(16'(i - 128), i);
        end
        check_total("ramp", -64'sd128);

        // Backpressure: 5 cycles stalled while inputs are offered.
        held = total_energy;
        energy_valid = 1'b1;
        energy       = 16'sd5000;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_valid", longint'(total_valid), 64'sd1);
            chk("stall_energy", longint'(total_energy), longint'(held));
            chk("stall_ready_low", longint'(energy_ready), 64'sd0);
        end
        energy_valid = 1'b0;
        ack();
        frame_const(16'sd7);
        check_total("c7", 64'sd1792);
        ack();

        // Flush after 100 inputs of 1000, colliding with a handshake.
        for (int i = 0; i < 100; i++) send(16'sd1000, i);
        chk("pre_flush_busy", longint'(busy), 64'sd1);
        flush        = 1'b1;
        energy_valid = 1'b1;
        energy       = 16'sd1000;
        tick();
        flush        = 1'b0;
        energy_valid = 1'b0;
        chk("flush_idx", longint'(spin_idx), 64'sd0);
        chk("flush_busy", longint'(busy), 64'sd0);
        frame_const(16'sd1);
        check_total("ones", 64'sd256);

        // Flush while a total is pending: valid drops, value is kept.
        flush       = 1'b1;
        total_ready = 1'b1;
        tick();
        flush       = 1'b0;
        total_ready = 1'b0;
        chk("flush_out_valid", longint'(total_valid), 64'sd0);
        chk("flush_out_energy", longint'(total_energy), 64'sd256);
        chk("flush_out_ready", longint'(energy_ready), 64'sd1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 50; i++) send(16'sd3, i);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready", longint'(energy_ready), 64'sd0);
        chk("arst_valid", longint'(total_valid), 64'sd0);
        chk("arst_energy", longint'(total_energy), 64'sd0);
        chk("arst_idx", longint'(spin_idx), 64'sd0);
        chk("arst_busy", longint'(busy), 64'sd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        frame_const(16'sd2);
        check_total("after_rst", 64'sd512);
        ack();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_energy_accumulator
